// File: rtl/lc3_mem_pkg.sv
// Shared types and helpers for the LC3 bench memory responder.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } port_state_t;

  localparam int LAT_CW  = 4;
  localparam int MAX_LAT = (1 << LAT_CW) - 1;

  // Upper address bits beyond the array depth alias onto the low words.
  function automatic logic [31:0] mem_idx(input logic [31:0] addr, input int depth_w);
    return addr & ((32'd1 << depth_w) - 32'd1);
  endfunction

  function automatic bit lat_ok(input int lat);
    return (lat >= 1) && (lat <= MAX_LAT);
  endfunction

endpackage

// File: rtl/lc3_mem_port_fsm.sv
// Per-port IDLE/WAIT/DONE sequencer: wait-state counter and one-cycle completion pulse.
module lc3_mem_port_fsm
  import lc3_mem_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic accept,
  output logic enter_done,
  output logic complete,
  output logic busy
);

  if (!lat_ok(LAT)) begin : g_bad_lat
    $error("lc3_mem_port_fsm: LAT must be in 1..15");
  end

  port_state_t             state;
  logic [LAT_CW-1:0]       cnt;

  assign accept     = (state == IDLE) && req;
  // True on the edge that moves the port into DONE.
  assign enter_done = (accept && (LAT == 1)) || ((state == WAIT) && (cnt == LAT_CW'(1)));
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      complete <= 1'b0;
    end else begin
      complete <= enter_done;
      case (state)
        IDLE: begin
          if (req) begin
            if (LAT == 1) begin
              state <= DONE;
            end else begin
              state <= WAIT;
              cnt   <= LAT_CW'(LAT - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == LAT_CW'(1)) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - LAT_CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// Wait-state memory responder serving the LC3 fetch and data ports, with a backdoor preload port.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH_W = 10,
  parameter int I_LAT   = 1,
  parameter int D_LAT   = 2,
  parameter int UNIFIED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instrmem_rd,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] Instr_dout,
  output logic              complete_instr,
  input  logic              Data_req,
  input  logic              Data_rd,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic [DATA_W-1:0] Data_din,
  output logic [DATA_W-1:0] Data_dout,
  output logic              complete_data,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy
);

  localparam int DEPTH = 1 << DEPTH_W;

  logic [DEPTH_W-1:0] i_idx, d_idx, l_idx;
  logic [DATA_W-1:0]  i_word, d_word, i_hold, d_hold;
  logic               i_acc, i_done_edge, i_busy;
  logic               d_acc, d_done_edge, d_busy;
  logic               d_we, d_rd_q, d_rd_now;

  assign i_idx = DEPTH_W'(mem_idx(32'(pc), DEPTH_W));
  assign d_idx = DEPTH_W'(mem_idx(32'(Data_addr), DEPTH_W));
  assign l_idx = DEPTH_W'(mem_idx(32'(load_addr), DEPTH_W));

  lc3_mem_port_fsm #(.LAT(I_LAT)) u_i_fsm (
    .clk        (clk),
    .reset      (reset),
    .req        (instrmem_rd),
    .accept     (i_acc),
    .enter_done (i_done_edge),
    .complete   (complete_instr),
    .busy       (i_busy)
  );

  lc3_mem_port_fsm #(.LAT(D_LAT)) u_d_fsm (
    .clk        (clk),
    .reset      (reset),
    .req        (Data_req),
    .accept     (d_acc),
    .enter_done (d_done_edge),
    .complete   (complete_data),
    .busy       (d_busy)
  );

  assign busy = i_busy | d_busy;
  assign d_we = d_acc & ~Data_rd;

  // Backdoor load is written last so it wins over a same-edge data write.
  if (UNIFIED != 0) begin : g_unified
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (d_we)    mem[d_idx] <= Data_din;
      if (load_en) mem[l_idx] <= load_data;
    end
    assign i_word = mem[i_idx];
    assign d_word = mem[d_idx];
  end else begin : g_split
    logic [DATA_W-1:0] imem [DEPTH];
    logic [DATA_W-1:0] dmem [DEPTH];
    always_ff @(posedge clk) begin
      if (load_en) imem[l_idx] <= load_data;
      if (d_we)    dmem[d_idx] <= Data_din;
      if (load_en) dmem[l_idx] <= load_data;
    end
    assign i_word = imem[i_idx];
    assign d_word = dmem[d_idx];
  end

  // Holding registers capture the old array word at acceptance (read-before-write).
  always_ff @(posedge clk) begin
    if (i_acc) i_hold <= i_word;
    if (d_acc) begin
      d_rd_q <= Data_rd;
      if (Data_rd) d_hold <= d_word;
    end
  end

  // With a single wait state DONE is entered on the acceptance edge itself.
  assign d_rd_now = (D_LAT == 1) ? Data_rd : d_rd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Instr_dout <= '0;
      Data_dout  <= '0;
    end else begin
      if (i_done_edge)
        Instr_dout <= (I_LAT == 1) ? i_word : i_hold;
      if (d_done_edge && d_rd_now)
        Data_dout  <= (D_LAT == 1) ? d_word : d_hold;
    end
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench: instance A (I_LAT=1, D_LAT=3, unified) and instance B (I_LAT=2, D_LAT=1, split).
module tb_lc3_mem_responder;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  logic        a_instrmem_rd, a_Data_req, a_Data_rd, a_load_en;
  logic [15:0] a_pc, a_Data_addr, a_Data_din, a_load_addr, a_load_data;
  logic [15:0] a_Instr_dout, a_Data_dout;
  logic        a_complete_instr, a_complete_data, a_busy;

  logic        b_instrmem_rd, b_Data_req, b_Data_rd, b_load_en;
  logic [15:0] b_pc, b_Data_addr, b_Data_din, b_load_addr, b_load_data;
  logic [15:0] b_Instr_dout, b_Data_dout;
  logic        b_complete_instr, b_complete_data, b_busy;

  lc3_mem_responder #(
    .DATA_W(16), .ADDR_W(16), .DEPTH_W(10), .I_LAT(1), .D_LAT(3), .UNIFIED(1)
  ) u_a (
    .clk(clk), .reset(rst_n),
    .instrmem_rd(a_instrmem_rd), .pc(a_pc), .Instr_dout(a_Instr_dout),
    .complete_instr(a_complete_instr),
    .Data_req(a_Data_req), .Data_rd(a_Data_rd), .Data_addr(a_Data_addr),
    .Data_din(a_Data_din), .Data_dout(a_Data_dout), .complete_data(a_complete_data),
    .load_en(a_load_en), .load_addr(a_load_addr), .load_data(a_load_data),
    .busy(a_busy)
  );

  lc3_mem_responder #(
    .DATA_W(16), .ADDR_W(16), .DEPTH_W(10), .I_LAT(2), .D_LAT(1), .UNIFIED(0)
  ) u_b (
    .clk(clk), .reset(rst_n),
    .instrmem_rd(b_instrmem_rd), .pc(b_pc), .Instr_dout(b_Instr_dout),
    .complete_instr(b_complete_instr),
    .Data_req(b_Data_req), .Data_rd(b_Data_rd), .Data_addr(b_Data_addr),
    .Data_din(b_Data_din), .Data_dout(b_Data_dout), .complete_data(b_complete_data),
    .load_en(b_load_en), .load_addr(b_load_addr), .load_data(b_load_data),
    .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_load(input logic [15:0] addr, input logic [15:0] data);
    a_load_en = 1'b1; a_load_addr = addr; a_load_data = data;
    cycle();
    a_load_en = 1'b0;
  endtask

  task automatic b_load(input logic [15:0] addr, input logic [15:0] data);
    b_load_en = 1'b1; b_load_addr = addr; b_load_data = data;
    cycle();
    b_load_en = 1'b0;
  endtask

  // Fetch on A (I_LAT=1): completion on the sample right after acceptance.
  task automatic a_fetch(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    a_instrmem_rd = 1'b1; a_pc = addr;
    cycle();
    check({tag, "_cmp"}, a_complete_instr, 1'b1);
    check({tag, "_dout"}, a_Instr_dout, exp);
    a_instrmem_rd = 1'b0;
    cycle();
    check({tag, "_cmp_end"}, a_complete_instr, 1'b0);
  endtask

  // Data access on A (D_LAT=3): pulse only on the third sample after acceptance.
  task automatic a_data(input string tag, input logic rd, input logic [15:0] addr,
                        input logic [15:0] din, input logic [15:0] exp_dout);
    a_Data_req = 1'b1; a_Data_rd = rd; a_Data_addr = addr; a_Data_din = din;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      check({tag, "_cmp"}, a_complete_data, (k == 3));
    end
    check({tag, "_busy"}, a_busy, 1'b1);
    check({tag, "_dout"}, a_Data_dout, exp_dout);
    a_Data_req = 1'b0;
    cycle();
    check({tag, "_cmp_end"}, a_complete_data, 1'b0);
    check({tag, "_idle"}, a_busy, 1'b0);
  endtask

  // Data access on B (D_LAT=1).
  task automatic b_data(input string tag, input logic rd, input logic [15:0] addr,
                        input logic [15:0] din, input logic [15:0] exp_dout);
    b_Data_req = 1'b1; b_Data_rd = rd; b_Data_addr = addr; b_Data_din = din;
    cycle();
    check({tag, "_cmp"}, b_complete_data, 1'b1);
    check({tag, "_dout"}, b_Data_dout, exp_dout);
    b_Data_req = 1'b0;
    cycle();
    check({tag, "_cmp_end"}, b_complete_data, 1'b0);
  endtask

  // Fetch on B (I_LAT=2): pulse on the second sample after acceptance.
  task automatic b_fetch(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    b_instrmem_rd = 1'b1; b_pc = addr;
    cycle();
    check({tag, "_cmp1"}, b_complete_instr, 1'b0);
    cycle();
    check({tag, "_cmp2"}, b_complete_instr, 1'b1);
    check({tag, "_dout"}, b_Instr_dout, exp);
    b_instrmem_rd = 1'b0;
    cycle();
    check({tag, "_cmp_end"}, b_complete_instr, 1'b0);
  endtask

  logic [8:0] held_pattern;

  initial begin
    rst_n = 1'b0;
    a_instrmem_rd = 0; a_Data_req = 0; a_Data_rd = 0; a_load_en = 0;
    a_pc = 0; a_Data_addr = 0; a_Data_din = 0; a_load_addr = 0; a_load_data = 0;
    b_instrmem_rd = 0; b_Data_req = 0; b_Data_rd = 0; b_load_en = 0;
    b_pc = 0; b_Data_addr = 0; b_Data_din = 0; b_load_addr = 0; b_load_data = 0;

    cycle();
    cycle();
    check("rst_a_idout", a_Instr_dout, 16'h0000);
    check("rst_a_ddout", a_Data_dout, 16'h0000);
    check("rst_a_cmp", {a_complete_instr, a_complete_data, a_busy}, 3'b000);
    check("rst_b_cmp", {b_complete_instr, b_complete_data, b_busy}, 3'b000);
    rst_n = 1'b1;
    cycle();

    // Preload and single-cycle fetch.
    a_load(16'h0010, 16'h1234);
    a_fetch("fetch10", 16'h0010, 16'h1234);

    // D_LAT=3 write then read; a later write leaves Data_dout alone.
    a_data("wr20", 1'b0, 16'h0020, 16'hBEEF, 16'h0000);
    a_data("rd20", 1'b1, 16'h0020, 16'h0000, 16'hBEEF);
    a_data("wr21", 1'b0, 16'h0021, 16'h1357, 16'hBEEF);

    // Same-edge fetch and data write to one address: fetch sees the old word.
    a_load(16'h0030, 16'h1111);
    a_instrmem_rd = 1'b1; a_pc = 16'h0030;
    a_Data_req = 1'b1; a_Data_rd = 1'b0; a_Data_addr = 16'h0030; a_Data_din = 16'h2222;
    cycle();
    check("rbw_icmp", a_complete_instr, 1'b1);
    check("rbw_idout", a_Instr_dout, 16'h1111);
    a_instrmem_rd = 1'b0;
    cycle();
    check("rbw_dcmp1", a_complete_data, 1'b0);
    cycle();
    check("rbw_dcmp2", a_complete_data, 1'b1);
    check("rbw_ddout", a_Data_dout, 16'hBEEF);
    a_Data_req = 1'b0;
    cycle();
    a_fetch("rbw_refetch", 16'h0030, 16'h2222);

    // Held fetch request with I_LAT=2: one pulse every third cycle.
    b_load(16'h0040, 16'h4444);
    held_pattern = 9'b010010010;
    b_instrmem_rd = 1'b1; b_pc = 16'h0040;
    for (int k = 0; k < 9; k++) begin
      cycle();
      check($sformatf("held_cmp%0d", k), b_complete_instr, held_pattern[8-k]);
    end
    check("held_dout", b_Instr_dout, 16'h4444);
    b_instrmem_rd = 1'b0;
    cycle();
    cycle();
    check("held_idle", b_busy, 1'b0);

    // Reset during data WAIT: no pulse, outputs cleared, committed write survives.
    a_Data_req = 1'b1; a_Data_rd = 1'b0; a_Data_addr = 16'h0050; a_Data_din = 16'h5A5A;
    cycle();
    cycle();
    check("abort_busy", a_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_cmp", a_complete_data, 1'b0);
    check("abort_outs", {a_Instr_dout, a_Data_dout}, 32'h0000_0000);
    check("abort_busy0", a_busy, 1'b0);
    cycle();
    check("abort_cmp_hold", a_complete_data, 1'b0);
    a_Data_req = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    check("abort_cmp_after", a_complete_data, 1'b0);
    a_data("abort_rd50", 1'b1, 16'h0050, 16'h0000, 16'h5A5A);

    // Aliasing on split arrays: data write at 0x0405 lands on 0x0005; fetch side untouched.
    b_load(16'h0005, 16'hAAAA);
    b_data("alias_wr", 1'b0, 16'h0405, 16'h5555, 16'h0000);
    b_data("alias_rd", 1'b1, 16'h0005, 16'h0000, 16'h5555);
    b_fetch("alias_fetch", 16'h0005, 16'hAAAA);

    // Load and data write on the same edge and address: load wins.
    b_Data_req = 1'b1; b_Data_rd = 1'b0; b_Data_addr = 16'h0060; b_Data_din = 16'h0BAD;
    b_load_en = 1'b1; b_load_addr = 16'h0060; b_load_data = 16'h600D;
    cycle();
    b_load_en = 1'b0; b_Data_req = 1'b0;
    cycle();
    b_data("loadwin_rd", 1'b1, 16'h0060, 16'h0000, 16'h600D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc3_mem_responder.md
Name: lc3_mem_responder

Overview:
- Parametrised, cycle-accurate memory responder for the LC3 bench. Serves the DUT's instruction-fetch port and data port with independently configurable wait-state latency.
- Holds one unified array or two split arrays, selected by parameter.
- Replaces the fixed single-cycle memory model behind the driver interface. Adds a backdoor preload port for test setup.

Parameters:
- DATA_W, 16, word width of all data buses.
- ADDR_W, 16, width of pc and Data_addr.
- DEPTH_W, 10, array depth is 2**DEPTH_W words; the upper address bits are ignored (aliasing).
- I_LAT, 1, instruction wait cycles, legal 1..15.
- D_LAT, 2, data wait cycles, legal 1..15.
- UNIFIED, 1, 1 = one shared array; 0 = separate instruction and data arrays.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- instrmem_rd  in  1  instruction fetch request
- pc  in  ADDR_W  fetch address
- Instr_dout  out  DATA_W  fetched word
- complete_instr  out  1  one-cycle fetch completion pulse
- Data_req  in  1  data access request
- Data_rd  in  1  1 = read, 0 = write
- Data_addr  in  ADDR_W  data address
- Data_din  in  DATA_W  write data
- Data_dout  out  DATA_W  read data
- complete_data  out  1  one-cycle data completion pulse
- load_en  in  1  backdoor write strobe
- load_addr  in  ADDR_W  backdoor address
- load_data  in  DATA_W  backdoor data
- busy  out  1  OR of both ports not IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - Both port FSMs go to IDLE and counters clear.
  - Instr_dout, Data_dout = 0; complete_instr, complete_data, busy = 0.
  - Array contents are not reset.
- Each port has its own FSM with states IDLE, WAIT, DONE.
- IDLE:
  - Request sampled at a rising edge (instrmem_rd, or Data_req for the data port) is accepted.
  - Address is latched. For a read, the array word is captured into a holding register at acceptance.
  - Transitions: wait count = 1 goes directly to DONE; otherwise to WAIT with counter = LAT-1.
- WAIT: counter decrements each cycle; at counter 1, go to DONE.
- DONE:
  - complete_* = 1 for exactly one cycle.
  - *_dout is updated from the holding register on the edge entering DONE.
  - Always returns to IDLE; no acceptance occurs in DONE.
- Timing and throughput:
  - Request accepted at edge N gives complete high during cycle N+LAT.
  - Maximum rate is one access per LAT+1 cycles per port.
- Requests while in WAIT or DONE are ignored. The requester holds the request until it sees complete.
- Outputs:
  - Instr_dout and Data_dout hold their value until the next completion on the same port.
  - Data_dout is unchanged on a write completion.
- Writes: the data write is committed to the array at the acceptance edge.
- Same-edge conflicts:
  - Instruction read and data write to the same address with UNIFIED=1: the read returns the old word (read-before-write).
  - Data read after a write: a later-accepted read returns the new data.
- Backdoor load:
  - load_en writes the array at any time, in any state. With UNIFIED=0 it writes both arrays.
  - Same edge and same address as a data write: load_en wins.
  - A load does not alter an already-captured holding register.
- Ports are fully independent; simultaneous acceptance on both ports is legal (dual-read array).
- Reset mid-operation: the access is aborted and no complete pulse is issued. Any write already committed at acceptance remains.
- Parameters outside the legal latency range are caught by an elaboration-time assertion.

Decomposition:
- Shared package lc3_mem_pkg holds:
  - a state typedef with enum IDLE/WAIT/DONE;
  - the latency counter width constant LAT_CW = 4;
  - address index helper functions.
- One sub-module, lc3_mem_port_fsm (parameter LAT), holds the FSM, counter and complete pulse. It is instantiated twice.
- The array and holding registers live in the top level.

Test Plan:
- Reset then preload via load_en addr 0x0010=0x1234; instrmem_rd with pc=0x0010, I_LAT=1 -> complete_instr high on the next cycle, Instr_dout=0x1234.
- D_LAT=3: data write addr 0x0020=0xBEEF, then read 0x0020 -> each complete_data exactly 3 cycles after acceptance; Data_dout=0xBEEF; Data_dout unchanged after the write.
- UNIFIED=1: same-edge instr read of 0x0030 (old 0x1111) and data write 0x2222 -> Instr_dout=0x1111; a later fetch returns 0x2222.
- Held request while busy, I_LAT=2 -> exactly one complete_instr per 3 cycles; no extra pulse.
- reset asserted during data WAIT -> complete_data never pulses; outputs are 0; a write accepted before reset is readable after.
- DEPTH_W=10: write to 0x0405, read 0x0005 -> aliased data returned; UNIFIED=0 fetch of 0x0005 returns the preloaded instruction word, not the data write.
